// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// ID-stage hazard unit: load-use and multi-cycle FP RAW/structural stall
// detection, FP issue/busy/writeback sequencing with float write-port
// arbitration against MEM/WB, and pipeline enable/bubble generation.
// Optional macro STALL_PERF_CNT_EN adds saturating stall counters; without it
// both counter outputs are tied to zero.
module hazard_stall_controller #(
  parameter int FP_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic             uses_rs_ID,
  input  logic             uses_rt_ID,
  input  logic             float_src_ID,
  input  logic             fp_issue_ID,
  input  logic [4:0]       fp_dest_ID,
  input  logic             MemRead_ID_EX,
  input  logic             GeneralRegWrite_ID_EX,
  input  logic             FloatRegWrite_ID_EX,
  input  logic [4:0]       write_reg_ID_EX,
  input  logic             FloatRegWrite_MEM_WB,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             id_ex_bubble,
  output logic             fp_accept,
  output logic             fp_busy,
  output logic             fp_wb_valid,
  output logic [4:0]       fp_wb_reg,
  output logic [CNT_W-1:0] load_use_stalls,
  output logic [CNT_W-1:0] fp_stalls
);

  localparam int CNT_BITS = (FP_LATENCY > 1) ? $clog2(FP_LATENCY) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(FP_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    WB_WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [4:0]          fp_dest_q;

  logic load_use;
  logic fp_raw;
  logic fp_struct;
  logic stall;
  logic ex_writes_src_file;

  // Hazard detection and pipeline control from current state and ID/EX inputs
  always_comb begin
    ex_writes_src_file = float_src_ID ? FloatRegWrite_ID_EX : GeneralRegWrite_ID_EX;
    load_use = MemRead_ID_EX && (write_reg_ID_EX != 5'd0) && ex_writes_src_file &&
               ((uses_rs_ID && (rs_ID == write_reg_ID_EX)) ||
                (uses_rt_ID && (rt_ID == write_reg_ID_EX)));
    fp_busy   = (state_q != IDLE);
    fp_raw    = fp_busy && float_src_ID &&
                ((uses_rs_ID && (rs_ID == fp_dest_q)) ||
                 (uses_rt_ID && (rt_ID == fp_dest_q)));
    fp_struct = fp_issue_ID && fp_busy;
    stall     = load_use || fp_raw || fp_struct;

    pc_write_en    = !stall;
    if_id_write_en = !stall;
    id_ex_bubble   = stall;
    fp_accept      = fp_issue_ID && !stall;
  end

  // FSM state, latency counter and latched FP destination
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      fp_dest_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fp_accept) begin
        fp_dest_q <= fp_dest_ID;
      end
    end
  end

  // FSM next state and writeback grant; MEM/WB always wins the float write port
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fp_wb_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (fp_accept) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end else if (!FloatRegWrite_MEM_WB) begin
          fp_wb_valid = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = WB_WAIT;
        end
      end
      WB_WAIT: begin
        if (!FloatRegWrite_MEM_WB) begin
          fp_wb_valid = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    fp_wb_reg = fp_wb_valid ? fp_dest_q : 5'd0;
  end

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] load_use_cnt_q;
  logic [CNT_W-1:0] fp_cnt_q;

  // Saturating stall counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_use_cnt_q <= '0;
      fp_cnt_q       <= '0;
    end else begin
      if (load_use && (load_use_cnt_q != '1)) begin
        load_use_cnt_q <= load_use_cnt_q + CNT_W'(1);
      end
      if ((fp_raw || fp_struct) && (fp_cnt_q != '1)) begin
        fp_cnt_q <= fp_cnt_q + CNT_W'(1);
      end
    end
  end

  assign load_use_stalls = load_use_cnt_q;
  assign fp_stalls       = fp_cnt_q;
`else
  assign load_use_stalls = '0;
  assign fp_stalls       = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller
// Directed bench: table of single-cycle stall vectors in the idle state, then
// hand-written FP issue/writeback, write-port contention and mid-op reset
// sequences. Counter expectations follow STALL_PERF_CNT_EN.
module tb_hazard_stall_controller;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic [4:0]       rs_ID, rt_ID;
  logic             uses_rs_ID, uses_rt_ID;
  logic             float_src_ID;
  logic             fp_issue_ID;
  logic [4:0]       fp_dest_ID;
  logic             MemRead_ID_EX;
  logic             GeneralRegWrite_ID_EX;
  logic             FloatRegWrite_ID_EX;
  logic [4:0]       write_reg_ID_EX;
  logic             FloatRegWrite_MEM_WB;
  logic             pc_write_en, if_id_write_en, id_ex_bubble;
  logic             fp_accept, fp_busy, fp_wb_valid;
  logic [4:0]       fp_wb_reg;
  logic [CNT_W-1:0] load_use_stalls, fp_stalls;

  int checks = 0;
  int errors = 0;

  hazard_stall_controller #(
    .FP_LATENCY(4),
    .CNT_W     (CNT_W)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .rs_ID                (rs_ID),
    .rt_ID                (rt_ID),
    .uses_rs_ID           (uses_rs_ID),
    .uses_rt_ID           (uses_rt_ID),
    .float_src_ID         (float_src_ID),
    .fp_issue_ID          (fp_issue_ID),
    .fp_dest_ID           (fp_dest_ID),
    .MemRead_ID_EX        (MemRead_ID_EX),
    .GeneralRegWrite_ID_EX(GeneralRegWrite_ID_EX),
    .FloatRegWrite_ID_EX  (FloatRegWrite_ID_EX),
    .write_reg_ID_EX      (write_reg_ID_EX),
    .FloatRegWrite_MEM_WB (FloatRegWrite_MEM_WB),
    .pc_write_en          (pc_write_en),
    .if_id_write_en       (if_id_write_en),
    .id_ex_bubble         (id_ex_bubble),
    .fp_accept            (fp_accept),
    .fp_busy              (fp_busy),
    .fp_wb_valid          (fp_wb_valid),
    .fp_wb_reg            (fp_wb_reg),
    .load_use_stalls      (load_use_stalls),
    .fp_stalls            (fp_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       fsrc;
    logic       iss;
    logic       mr;
    logic       grw;
    logic       frw;
    logic [4:0] wr;
    logic       stall;
    logic       acc;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic fsrc,
                              input logic iss, input logic mr, input logic grw,
                              input logic frw, input logic [4:0] wr,
                              input logic stall, input logic acc);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.fsrc = fsrc; v.iss = iss;
    v.mr = mr; v.grw = grw; v.frw = frw; v.wr = wr; v.stall = stall; v.acc = acc;
    return v;
  endfunction

  function automatic int exp_cnt(input int n);
`ifdef STALL_PERF_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    rs_ID = '0; rt_ID = '0; uses_rs_ID = 1'b0; uses_rt_ID = 1'b0;
    float_src_ID = 1'b0; fp_issue_ID = 1'b0; fp_dest_ID = '0;
    MemRead_ID_EX = 1'b0; GeneralRegWrite_ID_EX = 1'b0; FloatRegWrite_ID_EX = 1'b0;
    write_reg_ID_EX = '0; FloatRegWrite_MEM_WB = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stall(input string name, input logic exp_stall);
    chk({name, ".pc_we"},  int'(pc_write_en),    int'(!exp_stall));
    chk({name, ".ifid_we"}, int'(if_id_write_en), int'(!exp_stall));
    chk({name, ".bubble"}, int'(id_ex_bubble),   int'(exp_stall));
  endtask

  task automatic chk_wb(input string name, input logic exp_v, input int exp_reg);
    chk({name, ".wb_valid"}, int'(fp_wb_valid), int'(exp_v));
    chk({name, ".wb_reg"},   int'(fp_wb_reg),   exp_reg);
  endtask

  initial begin
    vecs[0]  = mk(5'd9, 5'd0, 1, 0, 0, 0, 1, 1, 0, 5'd9, 1, 0); // load-use on rs
    vecs[1]  = mk(5'd9, 5'd0, 1, 0, 0, 0, 0, 1, 0, 5'd9, 0, 0); // load left EX
    vecs[2]  = mk(5'd0, 5'd0, 1, 0, 0, 0, 1, 1, 0, 5'd0, 0, 0); // reg 0 never hazard
    vecs[3]  = mk(5'd9, 5'd0, 1, 0, 1, 0, 1, 1, 0, 5'd9, 0, 0); // float src, general load
    vecs[4]  = mk(5'd9, 5'd0, 1, 0, 1, 0, 1, 0, 1, 5'd9, 1, 0); // float src, float load
    vecs[5]  = mk(5'd9, 5'd0, 0, 0, 0, 0, 1, 1, 0, 5'd9, 0, 0); // rs not read
    vecs[6]  = mk(5'd0, 5'd9, 0, 1, 0, 0, 1, 1, 0, 5'd9, 1, 0); // load-use on rt
    vecs[7]  = mk(5'd0, 5'd9, 0, 1, 0, 0, 1, 1, 0, 5'd8, 0, 0); // different dest
    vecs[8]  = mk(5'd9, 5'd0, 1, 0, 0, 0, 1, 0, 0, 5'd9, 0, 0); // load writes nothing
    vecs[9]  = mk(5'd9, 5'd0, 1, 0, 0, 1, 1, 1, 0, 5'd9, 1, 0); // FP issue blocked by load-use
    vecs[10] = mk(5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0); // quiet

    clear_in();
    rst_n = 1'b0;
    @(negedge clk);
    chk_stall("reset", 1'b0);
    chk("reset.busy", int'(fp_busy), 0);
    chk_wb("reset", 1'b0, 0);
    chk("reset.lu_cnt", int'(load_use_stalls), 0);
    chk("reset.fp_cnt", int'(fp_stalls), 0);
    #3 rst_n = 1'b1;
    next_cycle();

    // Idle-state stall table
    for (int i = 0; i < 11; i++) begin
      clear_in();
      rs_ID = vecs[i].rs; rt_ID = vecs[i].rt;
      uses_rs_ID = vecs[i].urs; uses_rt_ID = vecs[i].urt;
      float_src_ID = vecs[i].fsrc; fp_issue_ID = vecs[i].iss; fp_dest_ID = 5'd5;
      MemRead_ID_EX = vecs[i].mr; GeneralRegWrite_ID_EX = vecs[i].grw;
      FloatRegWrite_ID_EX = vecs[i].frw; write_reg_ID_EX = vecs[i].wr;
      @(negedge clk);
      chk_stall($sformatf("vec%0d", i), vecs[i].stall);
      chk($sformatf("vec%0d.accept", i), int'(fp_accept), int'(vecs[i].acc));
      chk($sformatf("vec%0d.busy", i), int'(fp_busy), 0);
      next_cycle();
    end

    // FP issue dest 5, RAW reader on rt=5, second issue (dest 7) held until c5
    clear_in();
    fp_issue_ID = 1'b1; fp_dest_ID = 5'd5;
    @(negedge clk);
    chk("fpA.c0.accept", int'(fp_accept), 1);
    chk("fpA.c0.busy", int'(fp_busy), 0);
    chk_stall("fpA.c0", 1'b0);
    chk("fpA.c0.lu_cnt", int'(load_use_stalls), exp_cnt(4));
    chk("fpA.c0.fp_cnt", int'(fp_stalls), exp_cnt(0));
    next_cycle();
    for (int c = 1; c <= 4; c++) begin
      clear_in();
      float_src_ID = 1'b1; uses_rt_ID = 1'b1; rt_ID = 5'd5;
      if (c >= 2) begin
        fp_issue_ID = 1'b1; fp_dest_ID = 5'd7;
      end
      @(negedge clk);
      chk($sformatf("fpA.c%0d.busy", c), int'(fp_busy), 1);
      chk_stall($sformatf("fpA.c%0d", c), 1'b1);
      chk($sformatf("fpA.c%0d.accept", c), int'(fp_accept), 0);
      chk_wb($sformatf("fpA.c%0d", c), c == 4, (c == 4) ? 5 : 0);
      next_cycle();
    end
    clear_in();
    float_src_ID = 1'b1; uses_rt_ID = 1'b1; rt_ID = 5'd5;
    fp_issue_ID = 1'b1; fp_dest_ID = 5'd7;
    @(negedge clk);
    chk("fpA.c5.busy", int'(fp_busy), 0);
    chk_stall("fpA.c5", 1'b0);
    chk("fpA.c5.accept", int'(fp_accept), 1);
    chk_wb("fpA.c5", 1'b0, 0);
    next_cycle();
    for (int c = 6; c <= 9; c++) begin
      clear_in();
      @(negedge clk);
      chk($sformatf("fpA.c%0d.busy", c), int'(fp_busy), 1);
      chk_stall($sformatf("fpA.c%0d", c), 1'b0);
      chk_wb($sformatf("fpA.c%0d", c), c == 9, (c == 9) ? 7 : 0);
      next_cycle();
    end
    clear_in();
    @(negedge clk);
    chk("fpA.c10.busy", int'(fp_busy), 0);
    chk("fpA.c10.fp_cnt", int'(fp_stalls), exp_cnt(4));
    chk("fpA.c10.lu_cnt", int'(load_use_stalls), exp_cnt(4));
    next_cycle();

    // MEM/WB owns the float write port in c4..c5: writeback deferred to c6
    clear_in();
    fp_issue_ID = 1'b1; fp_dest_ID = 5'd3;
    @(negedge clk);
    chk("fpB.c0.accept", int'(fp_accept), 1);
    next_cycle();
    for (int c = 1; c <= 5; c++) begin
      clear_in();
      FloatRegWrite_MEM_WB = (c >= 4);
      @(negedge clk);
      chk($sformatf("fpB.c%0d.busy", c), int'(fp_busy), 1);
      chk_wb($sformatf("fpB.c%0d", c), 1'b0, 0);
      next_cycle();
    end
    clear_in();
    @(negedge clk);
    chk("fpB.c6.busy", int'(fp_busy), 1);
    chk_wb("fpB.c6", 1'b1, 3);
    next_cycle();
    @(negedge clk);
    chk("fpB.c7.busy", int'(fp_busy), 0);
    chk_wb("fpB.c7", 1'b0, 0);
    next_cycle();

    // Two load-use stalls, then reset in the middle of an FP op
    for (int c = 0; c < 2; c++) begin
      clear_in();
      MemRead_ID_EX = 1'b1; GeneralRegWrite_ID_EX = 1'b1; write_reg_ID_EX = 5'd9;
      rs_ID = 5'd9; uses_rs_ID = 1'b1;
      @(negedge clk);
      chk_stall($sformatf("rstC.lu%0d", c), 1'b1);
      next_cycle();
    end
    clear_in();
    fp_issue_ID = 1'b1; fp_dest_ID = 5'd6;
    @(negedge clk);
    chk("rstC.c0.accept", int'(fp_accept), 1);
    chk("rstC.c0.lu_cnt", int'(load_use_stalls), exp_cnt(6));
    next_cycle();
    clear_in();
    @(negedge clk);
    chk("rstC.c1.busy", int'(fp_busy), 1);
    next_cycle();
    @(negedge clk);
    chk("rstC.c2.busy", int'(fp_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rstC.async.busy", int'(fp_busy), 0);
    chk_wb("rstC.async", 1'b0, 0);
    chk("rstC.async.lu_cnt", int'(load_use_stalls), 0);
    chk("rstC.async.fp_cnt", int'(fp_stalls), 0);
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      clear_in();
      @(negedge clk);
      chk($sformatf("rstC.post%0d.busy", c), int'(fp_busy), 0);
      chk_wb($sformatf("rstC.post%0d", c), 1'b0, 0);
      next_cycle();
    end
    @(negedge clk);
    chk("rstC.end.lu_cnt", int'(load_use_stalls), 0);
    chk("rstC.end.fp_cnt", int'(fp_stalls), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
